// File: rtl/vlc_bit_packer_if.sv
// Packed-word output stream between the bit packer and the bitstream writer.
// The packer is the master: it offers words, the writer accepts them with out_ready.
interface vlc_bit_packer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into 32-bit words,
// buffered in a small FIFO; a flush pads the last partial word with zeros.
//
// state | meaning
// RUN   | merging codewords; a flush with no same-cycle push pads immediately
// PAD   | flush residual still pending because the merge cycle already pushed
module vlc_bit_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        input_valid,
  input  logic [31:0]                 codeword,
  input  logic [31:0]                 codeword_length,
  input  logic                        flush,
  vlc_bit_packer_if.master            out_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 total_bits,
  output logic                        busy,
  output logic                        flush_done,
  output logic                        overflow,
  output logic                        length_error,
  output logic                        protocol_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, PAD} state_t;

  state_t      state, state_nxt;
  logic        s1_valid, s1_flush;
  logic [31:0] s1_code;
  logic [5:0]  s1_len;
  logic [63:0] acc, acc_nxt, placed, merged;
  logic [4:0]  cnt, cnt_nxt;
  logic [5:0]  c_sum, len_c;
  logic        pend, pend_nxt, done_nxt;
  logic        push;
  logic [31:0] push_data;
  logic        accept_in, accept_flush;

  assign accept_in    = input_valid & ~busy;
  assign accept_flush = flush & ~busy;
  assign len_c        = (codeword_length > 32'd32) ? 6'd32 : codeword_length[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid       <= 1'b0;
      s1_flush       <= 1'b0;
      s1_code        <= '0;
      s1_len         <= '0;
      length_error   <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      s1_valid <= accept_in;
      s1_flush <= accept_flush;
      s1_code  <= codeword & ~(32'hFFFF_FFFF << len_c);
      s1_len   <= accept_in ? len_c : 6'd0;
      if (accept_in && codeword_length > 32'd32)
        length_error <= 1'b1;
      if (busy && (input_valid || flush))
        protocol_error <= 1'b1;
    end
  end

  // Accumulator keeps its cnt valid bits left-aligned at bit 63.
  always_comb begin
    placed    = ({s1_code, 32'b0} << (6'd32 - s1_len)) >> cnt;
    merged    = acc | placed;
    c_sum     = {1'b0, cnt} + s1_len;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    pend_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (s1_valid && s1_len != 6'd0) begin
          if (c_sum[5]) begin
            push      = 1'b1;
            push_data = merged[63:32];
            acc_nxt   = {merged[31:0], 32'b0};
          end else begin
            acc_nxt = merged;
          end
          cnt_nxt = c_sum[4:0];
        end
        done_nxt = pend;
        if (s1_flush) begin
          if (cnt_nxt == 5'd0) begin
            pend_nxt = 1'b1;
          end else if (push) begin
            state_nxt = PAD;
          end else begin
            push      = 1'b1;
            push_data = acc_nxt[63:32];
            acc_nxt   = '0;
            cnt_nxt   = '0;
            pend_nxt  = 1'b1;
          end
        end
      end
      PAD: begin
        push      = 1'b1;
        push_data = acc[63:32];
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = RUN;
        done_nxt  = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      acc        <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      flush_done <= 1'b0;
      busy       <= 1'b0;
      total_bits <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      flush_done <= done_nxt;
      if (accept_flush)
        busy <= 1'b1;
      else if (done_nxt)
        busy <= 1'b0;
      if (s1_valid)
        total_bits <= total_bits + 32'(s1_len);
    end
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  assign full             = (fifo_level == LVL_FULL);
  assign pop              = out_if.out_valid & out_if.out_ready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign wr_en            = push & (~full | pop);
  assign out_if.out_valid = (fifo_level != '0);
  assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end
endmodule
